// File: rtl/btn_pkg.sv
// Shared encodings and sizing helpers for the button event controller.
// Pure compile-time content: no logic, no latency.
// No flow control of its own; consumers size ports and ticks from these helpers.
package btn_pkg;

  localparam logic EVT_PRESS   = 1'b1;
  localparam logic EVT_RELEASE = 1'b0;

  // Index width that stays at least one bit wide for a single button.
  function automatic int id_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Sample-tick period in clock cycles, shared so every block agrees on it.
  function automatic int tick_cyc(input int clk_freq, input int tick_us);
    return (clk_freq / 1_000_000) * tick_us;
  endfunction

endpackage

// File: rtl/btn_debounce_lane.sv
// Single-button 2-FF synchronizer plus tick-sampled debounce counter.
// Latency: 2 sync cycles + STABLE_TICKS ticks; flip is combinational on the accepting tick.
// No backpressure: flip is a 1-cycle strobe the parent must capture.
module btn_debounce_lane #(
  parameter int STABLE_TICKS = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic btn_raw,
  output logic state,
  output logic flip
);

  localparam int CW = $clog2(STABLE_TICKS + 1);
  localparam logic [CW-1:0] LAST = CW'(STABLE_TICKS - 1);

  logic [1:0]    sync_q;
  logic [CW-1:0] cnt;
  logic          mismatch;

  assign mismatch = (sync_q[1] != state);
  // Fires on the same tick that commits the new level, so the parent sees it at that edge.
  assign flip     = tick && mismatch && (cnt == LAST);

  // Synchronize the raw pin and count consecutive disagreeing ticks.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= '0;
      cnt    <= '0;
      state  <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], btn_raw};
      if (tick) begin
        if (mismatch) begin
          if (cnt == LAST) begin
            state <= sync_q[1];
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end else begin
          cnt <= '0;
        end
      end
    end
  end

endmodule

// File: rtl/btn_event_arb.sv
// Debounces NUM_BTN buttons on a shared tick and arbitrates press/release events round-robin.
// Latency: flip at edge E -> evt_valid at E+1 when the output register is free; 1 event/cycle sustained.
// Backpressure: evt_ready low holds the output; a second event per button overwrites pending and sets evt_ovf.
module btn_event_arb
  import btn_pkg::*;
#(
  parameter int CLK_FREQ     = 50_000_000,
  parameter int NUM_BTN      = 4,
  parameter int TICK_US      = 1000,
  parameter int STABLE_TICKS = 10,
  localparam int IDW         = id_width(NUM_BTN)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_BTN-1:0] btn_raw,
  output logic [NUM_BTN-1:0] btn_state,
  output logic               evt_valid,
  input  logic               evt_ready,
  output logic [IDW-1:0]     evt_id,
  output logic               evt_press,
  output logic [NUM_BTN-1:0] evt_ovf,
  input  logic [NUM_BTN-1:0] ovf_clr
);

  localparam int TICK_CYC = tick_cyc(CLK_FREQ, TICK_US);
  localparam int PW       = $clog2(TICK_CYC + 1);
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_CYC - 1);

  logic [PW-1:0]      pre_cnt;
  logic               tick;
  logic [NUM_BTN-1:0] flip;
  logic [NUM_BTN-1:0] pending;
  logic [NUM_BTN-1:0] pending_dir;
  logic [NUM_BTN-1:0] load;
  logic [IDW-1:0]     ptr;
  logic [IDW-1:0]     sel_idx;
  logic [IDW-1:0]     next_ptr;
  logic               sel_vld;
  logic               out_free;

  assign tick     = (pre_cnt == PRE_LAST);
  assign out_free = !evt_valid || evt_ready;

  // Shared prescaler producing the debounce sample tick.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pre_cnt <= '0;
    end else if (tick) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= pre_cnt + 1'b1;
    end
  end

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_lane
    btn_debounce_lane #(
      .STABLE_TICKS(STABLE_TICKS)
    ) u_lane (
      .clk    (clk),
      .rst_n  (rst_n),
      .tick   (tick),
      .btn_raw(btn_raw[g]),
      .state  (btn_state[g]),
      .flip   (flip[g])
    );
  end

  // Round-robin pick: first pending index at or above ptr, wrapping explicitly for any NUM_BTN.
  always_comb begin
    int idx;
    sel_vld = 1'b0;
    sel_idx = '0;
    idx     = 0;
    for (int k = 0; k < NUM_BTN; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_BTN) idx = idx - NUM_BTN;
      if (!sel_vld && pending[idx]) begin
        sel_vld = 1'b1;
        sel_idx = IDW'(idx);
      end
    end
    next_ptr = (int'(sel_idx) == NUM_BTN - 1) ? '0 : sel_idx + 1'b1;
    for (int i = 0; i < NUM_BTN; i++) begin
      load[i] = out_free && sel_vld && (int'(sel_idx) == i);
    end
  end

  // Capture flips into pending; a flip onto an unconsumed pending event overwrites it and flags loss.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending     <= '0;
      pending_dir <= '0;
      evt_ovf     <= '0;
    end else begin
      for (int i = 0; i < NUM_BTN; i++) begin
        if (flip[i]) begin
          pending[i]     <= 1'b1;
          pending_dir[i] <= ~btn_state[i];
        end else if (load[i]) begin
          pending[i] <= 1'b0;
        end
        if (flip[i] && pending[i] && !load[i]) begin
          evt_ovf[i] <= 1'b1;
        end else if (ovf_clr[i]) begin
          evt_ovf[i] <= 1'b0;
        end
      end
    end
  end

  // Output register: reload whenever free, hold id/press stable while stalled.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      evt_valid <= 1'b0;
      evt_id    <= '0;
      evt_press <= EVT_RELEASE;
      ptr       <= '0;
    end else if (out_free) begin
      if (sel_vld) begin
        evt_valid <= 1'b1;
        evt_id    <= sel_idx;
        evt_press <= pending_dir[sel_idx];
        ptr       <= next_ptr;
      end else begin
        evt_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/btn_event_arb.md
Name: btn_event_arb

Overview:
Multi-button input controller. Debounces NUM_BTN raw button pins against one shared sample-tick prescaler and records press and release events per button. A round-robin arbiter then shares a single valid/ready event channel among all buttons. The block sits between board button pins and the UI/command logic, replacing per-button free-running debounce counters.

Parameters:
CLK_FREQ, 50_000_000, clock frequency in Hz.
NUM_BTN, 4, number of buttons; legal range 1..16.
TICK_US, 1000, sample-tick period in us. TICK_CYC = (CLK_FREQ/1_000_000)*TICK_US; must be >= 1.
STABLE_TICKS, 10, consecutive ticks of disagreement required to accept a new level; must be >= 1.

Ports:
clk  in  1  system clock; the only clock.
rst_n  in  1  reset, synchronous, active-low.
btn_raw  in  NUM_BTN  raw button pins, active-high, asynchronous to clk.
btn_state  out  NUM_BTN  debounced level per button.
evt_valid  out  1  event available.
evt_ready  in  1  consumer accepts the event when evt_valid && evt_ready.
evt_id  out  IDW  button index; IDW = max(1, $clog2(NUM_BTN)).
evt_press  out  1  1 = press (0->1), 0 = release (1->0).
evt_ovf  out  NUM_BTN  sticky per-button "event lost" flag.
ovf_clr  in  NUM_BTN  1-cycle pulse clears the matching evt_ovf bit.

Behaviour:
- Reset (rst_n sampled low at a posedge) clears all state:
  - prescaler = 0; sync regs, btn_state, debounce counters, pending, pending_dir, evt_ovf = 0.
  - evt_valid = 0, evt_id = 0, evt_press = 0; round-robin pointer = 0.
  - Reset mid-transfer drops the output event and all pending events without a handshake.
  - A button held through reset produces a press event after normal debounce.
- Prescaler: counts 0..TICK_CYC-1 and wraps. tick is a 1-cycle strobe when count == TICK_CYC-1; with TICK_CYC = 1, tick is high every cycle.
- Sync: 2-FF synchronizer per button. Debounce uses the second stage (sync).
- Per-button debounce, evaluated only on tick cycles:
  - If sync != btn_state, cnt increments.
  - On the tick where cnt == STABLE_TICKS-1 with mismatch: btn_state <= sync, cnt <= 0, and a 1-cycle flip strobe fires.
  - If sync == btn_state on a tick, cnt <= 0.
  - cnt holds between ticks. Glitches that start and end between ticks are invisible by design.
- Pending capture, on flip[i] at edge E:
  - pending[i] <= 1 and pending_dir[i] <= new level, both effective at E.
  - If pending[i] was already 1 and is not being loaded into the output register at E: the new direction overwrites it and evt_ovf[i] <= 1.
  - If pending[i] is loaded into the output register at E: the new event becomes pending and no overflow is flagged.
- Output register (AXI-style):
  - The register is free when !evt_valid or (evt_valid && evt_ready).
  - When free and any pending bit is set: select the first set index searching upward from ptr with wrap-around. Load evt_id and evt_press, set evt_valid = 1, clear that pending bit, and set ptr = selected+1 (mod NUM_BTN).
  - When free and nothing is pending: evt_valid <= 0.
  - While evt_valid && !evt_ready, evt_id and evt_press hold stable.
  - Latency: flip at edge E gives evt_valid at edge E+1 if the register is free. With continuous ready, sustained throughput is 1 event/cycle.
- evt_ovf: set has priority over ovf_clr in the same cycle.
- Arithmetic:
  - cnt width is $clog2(STABLE_TICKS+1); cnt never exceeds STABLE_TICKS-1.
  - Prescaler width is $clog2(TICK_CYC+1).
  - Pointer wrap is computed explicitly; it does not rely on power-of-2 NUM_BTN.

Decomposition:
- Shared header/package btn_pkg:
  - EVT_PRESS = 1 and EVT_RELEASE = 0 encodings.
  - Width helper function max(1, clog2(n)).
  - TICK_CYC formula, so tick generation stays consistent across blocks.
- One sub-module, btn_debounce_lane: sync, cnt and btn_state for a single button, with inputs tick and btn_raw and outputs state and flip. Instantiated NUM_BTN times via generate.
- Prescaler, pending/overflow logic and the arbiter stay in btn_event_arb.

Test Plan:
Bench parameters for all scenarios: CLK_FREQ=1_000_000, TICK_US=10 (TICK_CYC=10), STABLE_TICKS=3, NUM_BTN=4, evt_ready=1 unless stated.
1. Clean press: btn_raw[2] 0->1 and held -> btn_state[2]=1 within 2+30 cycles; exactly one beat id=2, press=1 one cycle later; releasing gives exactly one id=2, press=0.
2. Bounce: btn_raw[1] toggles every 5 cycles for 60 cycles, then held 1 -> exactly one id=1 press; no release event; evt_ovf=0.
3. Short pulse: btn_raw[0] high for 15 cycles -> no event; btn_state[0] stays 0.
4. Round-robin: buttons 0, 1, 3 pressed in the same cycle after reset -> ids 0, 1, 3 on consecutive cycles. Then button 3 alone is pressed and released, leaving ptr=0. Releasing 0 and 1 together then gives ids 0, 1.
5. Backpressure/overflow: evt_ready=0; press, release, press btn 1 ->
   - Output holds id=1, press=1 throughout.
   - evt_ovf[1]=1; pending direction=1.
   - Raise evt_ready -> beats (1,press), (1,press).
   - ovf_clr[1] pulse -> evt_ovf[1]=0. ovf_clr in the same cycle as a new overflow leaves evt_ovf=1.
6. Reset mid-operation: with evt_valid=1, evt_ready=0 and btn 2 held, pulse rst_n=0 for 1 cycle -> next cycle evt_valid=0, btn_state=0, evt_ovf=0; a fresh id=2 press follows after debounce.
